// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce
// Brief   : Multi-channel pad synchroniser and debouncer producing a clean
//           level, one-cycle press/release pulses and a press toggle per bit.
// Rev     : 1.0  initial release
// ============================================================================
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle
);

  localparam int                 c_clog  = $clog2(DEBOUNCE_CYCLES);
  localparam int                 c_cnt_w = (c_clog < 1) ? 1 : c_clog;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_cond;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Polarity correction ahead of the synchroniser so "pressed" is always 1.
  assign w_cond = sw_raw ^ {WIDTH{ACTIVE_LOW}};

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_sync1 <= {WIDTH{RESET_LEVEL}};
      r_sync2 <= {WIDTH{RESET_LEVEL}};
    end else begin
      r_sync1 <= w_cond;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_level;
      logic               r_rise;
      logic               r_fall;
      logic               r_toggle;
      logic               w_s2;

      assign w_s2 = r_sync2[i];

      // Counter runs only while the synchronised input disagrees with the
      // accepted level; any agreement restarts the qualification window.
      always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_level  <= RESET_LEVEL;
          r_rise   <= 1'b0;
          r_fall   <= 1'b0;
          r_toggle <= 1'b0;
        end else if (w_s2 == r_level) begin
          r_cnt  <= '0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else if (r_cnt == c_last) begin
          r_cnt    <= '0;
          r_level  <= w_s2;
          r_rise   <= w_s2;
          r_fall   <= ~w_s2;
          r_toggle <= r_toggle ^ w_s2;
        end else begin
          r_cnt  <= r_cnt + c_cnt_w'(1);
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end
      end

      assign sw_level[i]  = r_level;
      assign sw_rise[i]   = r_rise;
      assign sw_fall[i]   = r_fall;
      assign sw_toggle[i] = r_toggle;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_debounce
// Brief   : Scoreboard bench for switch_debounce (8-cycle and 1-cycle builds).
// Rev     : 1.0  initial release
// ============================================================================
module tb_switch_debounce;

  typedef struct {
    int         cyc;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tog;
  } ev_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         cmp_n = 0;
  int         fail_n = 0;

  logic       rst_a;
  logic       rst_b;
  logic [3:0] raw_a;
  logic [3:0] raw_b;
  logic [3:0] level_a, rise_a, fall_a, tog_a;
  logic [3:0] level_b, rise_b, fall_b, tog_b;

  logic [3:0] m_lvl_a = 4'h0, m_tog_a = 4'h0;
  logic [3:0] m_lvl_b = 4'h0, m_tog_b = 4'h0;
  ev_t        q_a[$];
  ev_t        q_b[$];
  ev_t        cur_a;
  ev_t        cur_b;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1), .RESET_LEVEL(1'b0)) dut_a (
    .clk_50mhz(clk), .rst(rst_a), .sw_raw(raw_a),
    .sw_level(level_a), .sw_rise(rise_a), .sw_fall(fall_a), .sw_toggle(tog_a)
  );

  switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b1), .RESET_LEVEL(1'b0)) dut_b (
    .clk_50mhz(clk), .rst(rst_b), .sw_raw(raw_b),
    .sw_level(level_b), .sw_rise(rise_b), .sw_fall(fall_b), .sw_toggle(tog_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      fail_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw edge driven now is captured at the next edge; acceptance lands
  // 1 + DEBOUNCE_CYCLES edges after that capture.
  task automatic expect_a(input logic [3:0] rise, input logic [3:0] fall);
    ev_t e;
    m_lvl_a = (m_lvl_a | rise) & ~fall;
    m_tog_a = m_tog_a ^ rise;
    e.cyc = cyc + 2 + 8; e.level = m_lvl_a; e.rise = rise; e.fall = fall; e.tog = m_tog_a;
    q_a.push_back(e);
  endtask

  task automatic expect_b(input logic [3:0] rise, input logic [3:0] fall);
    ev_t e;
    m_lvl_b = (m_lvl_b | rise) & ~fall;
    m_tog_b = m_tog_b ^ rise;
    e.cyc = cyc + 2 + 1; e.level = m_lvl_b; e.rise = rise; e.fall = fall; e.tog = m_tog_b;
    q_b.push_back(e);
  endtask

  // Monitors: any pulse is an output event and must match the queue head.
  always @(negedge clk) begin
    if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      cmp_n++; fail_n++;
      $display("FAIL a_missing: pulse due at cycle %0d not seen by cycle %0d", q_a[0].cyc, cyc);
      void'(q_a.pop_front());
    end
    if ((rise_a | fall_a) != 4'h0) begin
      if (q_a.size() == 0) begin
        cmp_n++; fail_n++;
        $display("FAIL a_unexpected: rise=0x%0h fall=0x%0h at cycle %0d, expected none", rise_a, fall_a, cyc);
      end else begin
        cur_a = q_a.pop_front();
        chk("a_cycle", cyc, cur_a.cyc);
        chk("a_level", int'(level_a), int'(cur_a.level));
        chk("a_rise", int'(rise_a), int'(cur_a.rise));
        chk("a_fall", int'(fall_a), int'(cur_a.fall));
        chk("a_toggle", int'(tog_a), int'(cur_a.tog));
      end
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      cmp_n++; fail_n++;
      $display("FAIL b_missing: pulse due at cycle %0d not seen by cycle %0d", q_b[0].cyc, cyc);
      void'(q_b.pop_front());
    end
    if ((rise_b | fall_b) != 4'h0) begin
      if (q_b.size() == 0) begin
        cmp_n++; fail_n++;
        $display("FAIL b_unexpected: rise=0x%0h fall=0x%0h at cycle %0d, expected none", rise_b, fall_b, cyc);
      end else begin
        cur_b = q_b.pop_front();
        chk("b_cycle", cyc, cur_b.cyc);
        chk("b_level", int'(level_b), int'(cur_b.level));
        chk("b_rise", int'(rise_b), int'(cur_b.rise));
        chk("b_fall", int'(fall_b), int'(cur_b.fall));
        chk("b_toggle", int'(tog_b), int'(cur_b.tog));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    raw_a = 4'hF; raw_b = 4'hF;
    tick(4);
    chk("rst_level", int'(level_a), 0);
    chk("rst_toggle", int'(tog_a), 0);
    chk("rst_rise", int'(rise_a), 0);
    chk("rst_fall", int'(fall_a), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(20);
    chk("post_rst_level", int'(level_a), 0);
    chk("post_rst_toggle", int'(tog_a), 0);

    // Clean press of bit 0.
    raw_a[0] = 1'b0; expect_a(4'b0001, 4'b0000);
    tick(15);

    // Bounce on bit 1: 3-cycle plateaus never qualify.
    for (int i = 0; i < 13; i++) begin
      raw_a[1] = ~raw_a[1];
      tick(3);
    end
    raw_a[1] = 1'b1;
    tick(20);
    chk("bounce_level", int'(level_a), 4'b0001);

    // Bit 2: 7-cycle low rejected, 8-cycle low accepted, then release.
    raw_a[2] = 1'b0; tick(7); raw_a[2] = 1'b1;
    tick(12);
    raw_a[2] = 1'b0; expect_a(4'b0100, 4'b0000);
    tick(8);
    raw_a[2] = 1'b1; expect_a(4'b0000, 4'b0100);
    tick(15);

    raw_a[0] = 1'b1; expect_a(4'b0000, 4'b0001);
    tick(15);

    // Simultaneous press of bits 0 and 3; second press of bit 0.
    raw_a[0] = 1'b0; raw_a[3] = 1'b0; expect_a(4'b1001, 4'b0000);
    tick(15);
    raw_a[0] = 1'b1; raw_a[3] = 1'b1; expect_a(4'b0000, 4'b1001);
    tick(15);

    // Reset four cycles into a bit-1 count; full count needed afterwards.
    raw_a[1] = 1'b0;
    tick(6);
    rst_a = 1'b1; m_lvl_a = 4'h0; m_tog_a = 4'h0;
    tick(3);
    chk("midrst_level", int'(level_a), 0);
    chk("midrst_toggle", int'(tog_a), 0);
    chk("midrst_pulse", int'(rise_a | fall_a), 0);
    rst_a = 1'b0; expect_a(4'b0010, 4'b0000);
    tick(15);
    raw_a[1] = 1'b1; expect_a(4'b0000, 4'b0010);
    tick(15);

    // Single-cycle qualification build.
    raw_b[0] = 1'b0; expect_b(4'b0001, 4'b0000);
    tick(6);
    raw_b[0] = 1'b1; expect_b(4'b0000, 4'b0001);
    tick(6);
    raw_b[2] = 1'b0; expect_b(4'b0100, 4'b0000);
    tick(1);
    raw_b[2] = 1'b1; expect_b(4'b0000, 4'b0100);
    tick(8);

    chk("final_level_a", int'(level_a), int'(m_lvl_a));
    chk("final_toggle_a", int'(tog_a), int'(m_tog_a));
    chk("final_level_b", int'(level_b), int'(m_lvl_b));
    chk("final_toggle_b", int'(tog_b), int'(m_tog_b));
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
`default_nettype wire
